// File: rtl/sm3_pkg.sv
// rtl/sm3_pkg.sv - shared constants for the SM3 message sequencer
// Purpose: SM3 initial value, block geometry and sequencer FSM state encoding.
package sm3_pkg;

    // SM3 initial chaining value IV, word A in the most significant bits
    localparam logic [255:0] SM3_IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

    localparam int WORDS_PER_BLK = 16;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH = 3'd1;
    localparam logic [STATE_W-1:0] ST_CAPT  = 3'd2;
    localparam logic [STATE_W-1:0] ST_COMP  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/sm3_msg_buf.sv
// rtl/sm3_msg_buf.sv - 16x32 indexed message block buffer
// Purpose: collects the 16 words of one 512-bit message block.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   wr_en       write strobe
//   wr_idx      word index written (0 = first word of the block)
//   wr_data     word to write
//   block       512-bit block, word0 in [511:480]
module sm3_msg_buf
    import sm3_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [3:0]   wr_idx,
    input  logic [31:0]  wr_data,
    output logic [511:0] block
);

    // Ascending packed range puts word 0 in the most significant slot,
    // which is exactly the big-endian block layout the core expects.
    logic [0:WORDS_PER_BLK-1][31:0] words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words <= '0;
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    assign block = words;

endmodule

// File: rtl/sm3_msg_sequencer.sv
// rtl/sm3_msg_sequencer.sv - SRAM-to-SM3-core block sequencer with V chaining
// Purpose: on a rising ENABLE edge fetches BSR 512-bit blocks from message SRAM
//   starting at SAR_ADDR, feeds each to the compression core, chains V and
//   publishes the digest on TEMP_RES with SET_STR as completion status.
// Ports:
//   AHB_HCLK, AHB_HRESETN     clock, asynchronous active-low reset
//   ENABLE                    run request level; low while busy aborts
//   SAR_ADDR, BSR             start word address, number of blocks
//   MEM_REN, MEM_ADDR         SRAM read strobe and word address
//   MEM_RDATA                 SRAM data, one cycle after MEM_REN
//   CORE_START                one-cycle pulse, MSG_BLOCK/CORE_V_IN valid
//   MSG_BLOCK, CORE_V_IN      block and chaining value to the core
//   CORE_DONE, CORE_V_OUT     core completion pulse and next chaining value
//   TEMP_RES, SET_STR, BUSY   digest, done status, busy status
module sm3_msg_sequencer
    import sm3_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 13
) (
    input  logic              AHB_HCLK,
    input  logic              AHB_HRESETN,
    input  logic              ENABLE,
    input  logic [ADDR_W-1:0] SAR_ADDR,
    input  logic [CNT_W-1:0]  BSR,
    output logic              MEM_REN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [31:0]       MEM_RDATA,
    output logic              CORE_START,
    output logic [511:0]      MSG_BLOCK,
    output logic [255:0]      CORE_V_IN,
    input  logic              CORE_DONE,
    input  logic [255:0]      CORE_V_OUT,
    output logic [255:0]      TEMP_RES,
    output logic              SET_STR,
    output logic              BUSY
);

    logic [STATE_W-1:0] state;
    logic               en_q;
    logic               start_pend;
    logic [ADDR_W-1:0]  base_q;
    logic [CNT_W-1:0]   bsr_q;
    logic [CNT_W-1:0]   blk_cnt;
    logic [CNT_W-1:0]   blk_next;
    logic [3:0]         word_idx;
    logic [255:0]       v_q;
    logic [ADDR_W-1:0]  blk_off;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               start_req;
    logic               buf_wr_en;
    logic [3:0]         buf_wr_idx;

    assign start_req  = (state == ST_IDLE) && ENABLE && !en_q;
    assign blk_next   = blk_cnt + CNT_W'(1);
    // Address arithmetic is modulo 2^ADDR_W so a message may wrap past the top of SRAM.
    assign blk_off    = ADDR_W'({blk_cnt, 4'b0000});
    assign fetch_addr = base_q + blk_off + ADDR_W'(word_idx);

    assign MEM_REN    = (state == ST_FETCH);
    assign MEM_ADDR   = MEM_REN ? fetch_addr : '0;
    assign CORE_START = (state == ST_COMP) && start_pend;
    // V resets to IV internally, but the core-facing copy is only driven while a block is in flight.
    assign CORE_V_IN  = (state == ST_COMP) ? v_q : '0;

    // Read data lags the strobe by one cycle, so each FETCH cycle stores the
    // previous word and CAPT stores word 15. word_idx has wrapped to 0 in CAPT,
    // so word_idx-1 yields 15 there as well.
    assign buf_wr_en  = ((state == ST_FETCH) && (word_idx != 4'd0)) || (state == ST_CAPT);
    assign buf_wr_idx = word_idx - 4'd1;

    sm3_msg_buf u_msg_buf (
        .clk     (AHB_HCLK),
        .rst_n   (AHB_HRESETN),
        .wr_en   (buf_wr_en),
        .wr_idx  (buf_wr_idx),
        .wr_data (MEM_RDATA),
        .block   (MSG_BLOCK)
    );

    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETN) begin
        if (!AHB_HRESETN) begin
            state      <= ST_IDLE;
            // Treat ENABLE as already high out of reset: a level held through
            // reset must be toggled before it counts as a start request.
            en_q       <= 1'b1;
            start_pend <= 1'b0;
            base_q     <= '0;
            bsr_q      <= '0;
            blk_cnt    <= '0;
            word_idx   <= '0;
            v_q        <= SM3_IV;
            TEMP_RES   <= '0;
            SET_STR    <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            en_q <= ENABLE;
            if ((state != ST_IDLE) && !ENABLE) begin
                // Abort: results are left as they were, any later CORE_DONE lands in IDLE.
                state      <= ST_IDLE;
                start_pend <= 1'b0;
                BUSY       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_req) begin
                            base_q   <= SAR_ADDR;
                            bsr_q    <= BSR;
                            v_q      <= SM3_IV;
                            blk_cnt  <= '0;
                            word_idx <= '0;
                            SET_STR  <= 1'b0;
                            BUSY     <= 1'b1;
                            state    <= (BSR == '0) ? ST_DONE : ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        word_idx <= word_idx + 4'd1;
                        if (word_idx == 4'(WORDS_PER_BLK - 1)) begin
                            state <= ST_CAPT;
                        end
                    end
                    ST_CAPT: begin
                        start_pend <= 1'b1;
                        state      <= ST_COMP;
                    end
                    ST_COMP: begin
                        start_pend <= 1'b0;
                        if (CORE_DONE) begin
                            v_q      <= CORE_V_OUT;
                            blk_cnt  <= blk_next;
                            word_idx <= '0;
                            state    <= (blk_next == bsr_q) ? ST_DONE : ST_FETCH;
                        end
                    end
                    ST_DONE: begin
                        TEMP_RES <= v_q;
                        SET_STR  <= 1'b1;
                        BUSY     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sm3_msg_sequencer.sv
// tb/tb_sm3_msg_sequencer.sv - directed self-checking bench for sm3_msg_sequencer
module tb_sm3_msg_sequencer;

    localparam logic [255:0] IV       = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [255:0] ABC_DIG  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] ABCD_DIG = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [12:0]  sar_addr = '0;
    logic [12:0]  bsr_in = '0;
    logic         mem_ren;
    logic [12:0]  mem_addr;
    logic [31:0]  mem_rdata = 32'hdeadbeef;
    logic         core_start;
    logic [511:0] msg_block;
    logic [255:0] core_v_in;
    logic         core_done = 1'b0;
    logic [255:0] core_v_out = '0;
    logic [255:0] temp_res;
    logic         set_str;
    logic         busy;

    int errors = 0;
    int checks = 0;

    sm3_msg_sequencer dut (
        .AHB_HCLK    (clk),
        .AHB_HRESETN (rst_n),
        .ENABLE      (enable),
        .SAR_ADDR    (sar_addr),
        .BSR         (bsr_in),
        .MEM_REN     (mem_ren),
        .MEM_ADDR    (mem_addr),
        .MEM_RDATA   (mem_rdata),
        .CORE_START  (core_start),
        .MSG_BLOCK   (msg_block),
        .CORE_V_IN   (core_v_in),
        .CORE_DONE   (core_done),
        .CORE_V_OUT  (core_v_out),
        .TEMP_RES    (temp_res),
        .SET_STR     (set_str),
        .BUSY        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural SM3 compression ----------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        int s;
        s = n % 32;
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 9) ^ rotl(x, 17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] b);
        logic [31:0] w [0:67];
        logic [31:0] a, bb, c, d, e, f, g, h, ss1, ss2, tt1, tt2, tj, ff, gg;
        for (int j = 0; j < 16; j++) w[j] = b[511 - 32*j -: 32];
        for (int j = 16; j < 68; j++)
            w[j] = p1(w[j-16] ^ w[j-9] ^ rotl(w[j-3], 15)) ^ rotl(w[j-13], 7) ^ w[j-6];
        {a, bb, c, d, e, f, g, h} = v;
        for (int j = 0; j < 64; j++) begin
            tj  = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rotl(rotl(a, 12) + e + rotl(tj, j), 7);
            ss2 = ss1 ^ rotl(a, 12);
            ff  = (j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c));
            gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
            tt1 = ff + d + ss2 + (w[j] ^ w[j+4]);
            tt2 = gg + h + ss1 + w[j];
            d = c; c = rotl(bb, 9); bb = a; a = tt1;
            h = g; g = rotl(f, 19); f = e; e = p0(tt2);
        end
        return {a, bb, c, d, e, f, g, h} ^ v;
    endfunction

    // ---------------- SRAM and core models, logs ----------------
    logic [31:0]  mem [0:8191];
    logic [31:0]  rd_pend = 32'hdeadbeef;
    int           core_delay = 5;
    int           core_cnt = 0;
    logic [255:0] core_res = '0;
    int           n_reads = 0;
    int           n_starts = 0;
    int           n_busy = 0;
    logic [12:0]  addr_log [$];
    logic [255:0] vin_log [$];
    logic [255:0] vout_log [$];
    logic [511:0] blk_log [$];

    always @(negedge clk) begin
        mem_rdata = rd_pend;
        rd_pend   = mem_ren ? mem[mem_addr] : 32'hdeadbeef;
        if (mem_ren) begin
            n_reads++;
            addr_log.push_back(mem_addr);
        end
        if (busy) n_busy++;
        core_done = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_done  = 1'b1;
                core_v_out = core_res;
                vout_log.push_back(core_res);
            end
        end
        if (core_start) begin
            n_starts++;
            vin_log.push_back(core_v_in);
            blk_log.push_back(msg_block);
            core_res = sm3_cf(core_v_in, msg_block);
            core_cnt = core_delay;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        n_reads = 0; n_starts = 0; n_busy = 0;
        addr_log.delete(); vin_log.delete(); vout_log.delete(); blk_log.delete();
    endtask

    task automatic load_block(input logic [12:0] base, input logic [511:0] blk);
        logic [12:0] a;
        for (int i = 0; i < 16; i++) begin
            a = base + 13'(i);
            mem[a] = blk[511 - 32*i -: 32];
        end
    endtask

    task automatic start_run(input logic [12:0] sar, input logic [12:0] bsr);
        enable = 1'b0; sar_addr = sar; bsr_in = bsr;
        tick(1);
        clear_logs();
        enable = 1'b1;
        tick(1);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    logic [511:0] abc_blk, abcd_b0, abcd_b1, wrap_blk;
    logic [255:0] wrap_dig;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0;
        tick(2);
        checks++; if ({mem_ren, core_start, set_str, busy} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {mem_ren, core_start, set_str, busy}); end
        checks++; if (mem_addr !== 13'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
        checks++; if (msg_block !== '0) begin errors++; $display("FAIL reset_msg_block: got %h expected 0", msg_block); end
        checks++; if (core_v_in !== '0) begin errors++; $display("FAIL reset_core_v_in: got %h expected 0", core_v_in); end
        checks++; if (temp_res !== '0) begin errors++; $display("FAIL reset_temp_res: got %h expected 0", temp_res); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_abc();
        bit ok;
        int bad;
        load_block(13'h0010, abc_blk);
        core_delay = 5;
        start_run(13'h0010, 13'd1);
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abc_timeout: busy still %b expected 0", busy); end
        checks++; if (n_reads != 16) begin errors++; $display("FAIL abc_reads: got %0d expected 16", n_reads); end
        bad = (addr_log.size() != 16) ? 1 : 0;
        for (int i = 0; i < addr_log.size() && i < 16; i++) if (addr_log[i] !== 13'h0010 + 13'(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL abc_addr_seq: got %0d bad addresses expected 0", bad); end
        checks++; if (n_starts != 1) begin errors++; $display("FAIL abc_starts: got %0d expected 1", n_starts); end
        checks++; if (blk_log.size() < 1 || blk_log[0] !== abc_blk) begin errors++; $display("FAIL abc_msg_block: got %h expected %h", (blk_log.size() > 0) ? blk_log[0] : 512'h0, abc_blk); end
        checks++; if (vin_log.size() < 1 || vin_log[0] !== IV) begin errors++; $display("FAIL abc_v_in: got %h expected %h", (vin_log.size() > 0) ? vin_log[0] : 256'h0, IV); end
        checks++; if (temp_res !== ABC_DIG) begin errors++; $display("FAIL abc_digest: got %h expected %h", temp_res, ABC_DIG); end
        checks++; if (set_str !== 1'b1) begin errors++; $display("FAIL abc_set_str: got %b expected 1", set_str); end
        checks++; if (n_busy != 24) begin errors++; $display("FAIL abc_busy_cycles: got %0d expected 24", n_busy); end
    endtask

    task automatic test_no_restart();
        clear_logs();
        tick(30);
        checks++; if (n_reads != 0 || n_starts != 0 || busy !== 1'b0) begin errors++; $display("FAIL hold_no_restart: got reads=%0d starts=%0d busy=%b expected 0 0 0", n_reads, n_starts, busy); end
        checks++; if (set_str !== 1'b1) begin errors++; $display("FAIL hold_set_str: got %b expected 1", set_str); end
    endtask

    task automatic test_two_blocks();
        bit ok;
        int bad;
        load_block(13'h0100, abcd_b0);
        load_block(13'h0110, abcd_b1);
        start_run(13'h0100, 13'd2);
        sar_addr = 13'h0aaa; bsr_in = 13'd5;
        wait_idle(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL two_timeout: busy still %b expected 0", busy); end
        checks++; if (n_reads != 32) begin errors++; $display("FAIL two_reads: got %0d expected 32", n_reads); end
        bad = (addr_log.size() != 32) ? 1 : 0;
        for (int i = 0; i < addr_log.size() && i < 32; i++) if (addr_log[i] !== 13'h0100 + 13'(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL two_addr_seq: got %0d bad addresses expected 0", bad); end
        checks++; if (n_starts != 2) begin errors++; $display("FAIL two_starts: got %0d expected 2", n_starts); end
        checks++; if (vin_log.size() < 2 || vout_log.size() < 1 || vin_log[1] !== vout_log[0]) begin errors++; $display("FAIL two_chain: got %h expected %h", (vin_log.size() > 1) ? vin_log[1] : 256'h0, (vout_log.size() > 0) ? vout_log[0] : 256'h0); end
        checks++; if (temp_res !== ABCD_DIG) begin errors++; $display("FAIL two_digest: got %h expected %h", temp_res, ABCD_DIG); end
        checks++; if (set_str !== 1'b1) begin errors++; $display("FAIL two_set_str: got %b expected 1", set_str); end
    endtask

    task automatic test_bsr_zero();
        start_run(13'h0040, 13'd0);
        checks++; if (busy !== 1'b1 || set_str !== 1'b0) begin errors++; $display("FAIL bsr0_start: got busy=%b set_str=%b expected 1 0", busy, set_str); end
        tick(1);
        checks++; if (busy !== 1'b0 || set_str !== 1'b1) begin errors++; $display("FAIL bsr0_done: got busy=%b set_str=%b expected 0 1", busy, set_str); end
        checks++; if (temp_res !== IV) begin errors++; $display("FAIL bsr0_digest: got %h expected %h", temp_res, IV); end
        tick(3);
        checks++; if (n_reads != 0 || n_starts != 0) begin errors++; $display("FAIL bsr0_no_access: got reads=%0d starts=%0d expected 0 0", n_reads, n_starts); end
        checks++; if (n_busy != 1) begin errors++; $display("FAIL bsr0_busy_cycles: got %0d expected 1", n_busy); end
    endtask

    task automatic test_wrap();
        bit ok;
        int bad;
        logic [12:0] ea;
        load_block(13'h1ff8, wrap_blk);
        start_run(13'h1ff8, 13'd1);
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: busy still %b expected 0", busy); end
        bad = (addr_log.size() != 16) ? 1 : 0;
        for (int i = 0; i < addr_log.size() && i < 16; i++) begin
            ea = 13'h1ff8 + 13'(i);
            if (addr_log[i] !== ea) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_addr_seq: got %0d bad addresses expected 0", bad); end
        checks++; if (blk_log.size() < 1 || blk_log[0] !== wrap_blk) begin errors++; $display("FAIL wrap_msg_block: got %h expected %h", (blk_log.size() > 0) ? blk_log[0] : 512'h0, wrap_blk); end
        checks++; if (temp_res !== wrap_dig) begin errors++; $display("FAIL wrap_digest: got %h expected %h", temp_res, wrap_dig); end
    endtask

    task automatic test_abort();
        bit ok;
        core_delay = 40;
        start_run(13'h0010, 13'd1);
        for (int i = 0; i < 40 && n_starts == 0; i++) tick(1);
        checks++; if (n_starts != 1) begin errors++; $display("FAIL abort_reach_comp: got starts=%0d expected 1", n_starts); end
        tick(5);
        checks++; if (busy !== 1'b1 || core_v_in !== IV) begin errors++; $display("FAIL abort_in_comp: got busy=%b v_in=%h expected 1 %h", busy, core_v_in, IV); end
        enable = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b0 || mem_ren !== 1'b0 || core_start !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b ren=%b start=%b expected 0 0 0", busy, mem_ren, core_start); end
        tick(50);
        checks++; if (vout_log.size() != 1 || n_starts != 1) begin errors++; $display("FAIL abort_late_done: got dones=%0d starts=%0d expected 1 1", vout_log.size(), n_starts); end
        checks++; if (temp_res !== wrap_dig || set_str !== 1'b0) begin errors++; $display("FAIL abort_results_kept: got %h set_str=%b expected %h 0", temp_res, set_str, wrap_dig); end
        core_delay = 5;
        start_run(13'h0010, 13'd1);
        wait_idle(200, ok);
        checks++; if (!ok || temp_res !== ABC_DIG || vin_log.size() < 1 || vin_log[0] !== IV) begin errors++; $display("FAIL abort_restart: got ok=%b digest=%h expected 1 %h", ok, temp_res, ABC_DIG); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_run(13'h0010, 13'd1);
        for (int i = 0; i < 20 && n_reads < 5; i++) tick(1);
        checks++; if (n_reads < 5 || mem_ren !== 1'b1) begin errors++; $display("FAIL rstmid_in_fetch: got reads=%0d ren=%b expected >=5 1", n_reads, mem_ren); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_ren, core_start, set_str, busy} !== 4'b0 || mem_addr !== 13'h0) begin errors++; $display("FAIL rstmid_flags: got %b addr=%h expected 0000 0000", {mem_ren, core_start, set_str, busy}, mem_addr); end
        checks++; if (temp_res !== '0 || msg_block !== '0 || core_v_in !== '0) begin errors++; $display("FAIL rstmid_data: got temp_res=%h expected 0", temp_res); end
        tick(1);
        rst_n = 1'b1;
        clear_logs();
        tick(30);
        checks++; if (n_reads != 0 || n_starts != 0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_start: got reads=%0d starts=%0d busy=%b expected 0 0 0", n_reads, n_starts, busy); end
        start_run(13'h0010, 13'd1);
        wait_idle(200, ok);
        checks++; if (!ok || temp_res !== ABC_DIG || set_str !== 1'b1) begin errors++; $display("FAIL rstmid_rerun: got ok=%b digest=%h set_str=%b expected 1 %h 1", ok, temp_res, set_str, ABC_DIG); end
    endtask

    initial begin
        abc_blk = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
        abcd_b0 = {16{32'h61626364}};
        abcd_b1 = {32'h80000000, {14{32'h00000000}}, 32'h00000200};
        for (int i = 0; i < 16; i++) wrap_blk[511 - 32*i -: 32] = 32'h11223344 + 32'h01010101 * 32'(i);
        wrap_dig = sm3_cf(IV, wrap_blk);
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;

        test_reset();
        test_abc();
        test_no_restart();
        test_two_blocks();
        test_bsr_zero();
        test_wrap();
        test_abort();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
